// File: rtl/lzx_vote_panel_if.sv
// lzx_vote_panel_if -- bundle of the vote panel's control and result signals.
//   start       : request to open a vote window
//   vote_valid  : per-judge vote strobe (N_JUDGE bits)
//   vote_val    : per-judge vote value, 1 = yes (N_JUDGE bits)
//   busy        : window open or result being issued
//   done        : single-cycle result strobe
//   pass        : decision of the last completed window
//   yes_cnt     : yes votes captured (CW bits)
//   no_cnt      : no votes captured (CW bits)
//   voted       : per-judge capture mask (N_JUDGE bits)
// master = the side that requests votes, slave = the panel itself.
interface lzx_vote_panel_if #(
  parameter int N_JUDGE = 5
);
  localparam int CW = $clog2(N_JUDGE + 1);

  logic               start;
  logic [N_JUDGE-1:0] vote_valid;
  logic [N_JUDGE-1:0] vote_val;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CW-1:0]      yes_cnt;
  logic [CW-1:0]      no_cnt;
  logic [N_JUDGE-1:0] voted;

  modport master (
    output start, vote_valid, vote_val,
    input  busy, done, pass, yes_cnt, no_cnt, voted
  );

  modport slave (
    input  start, vote_valid, vote_val,
    output busy, done, pass, yes_cnt, no_cnt, voted
  );
endinterface

// File: rtl/lzx_vote_panel.sv
// lzx_vote_panel -- collects one vote per judge inside a bounded window and
// issues a pass/fail decision.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lzx_vote_panel_if.slave (start/vote inputs, registered results)
// FSM IDLE -> COLLECT -> RESULT -> IDLE. A window lasts until every judge has
// voted or TIMEOUT_CYC collect cycles have elapsed; silent judges abstain.
module lzx_vote_panel #(
  parameter int N_JUDGE     = 5,
  parameter int TIMEOUT_CYC = 8,
  parameter int PASS_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  lzx_vote_panel_if.slave   bus
);
  localparam int CW = $clog2(N_JUDGE + 1);
  localparam logic [15:0]   LAST_TICK = 16'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'(N_JUDGE / 2);
  localparam logic [CW-1:0] ALL_CNT   = CW'(N_JUDGE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // Number of set bits in a judge mask.
  function automatic logic [CW-1:0] popcount(input logic [N_JUDGE-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_JUDGE; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  state_t             state_r, state_s;
  logic [15:0]        timer_r, timer_s;
  logic [N_JUDGE-1:0] voted_r, voted_s;
  logic [CW-1:0]      yes_r, yes_s;
  logic [CW-1:0]      no_r, no_s;
  logic               pass_r, pass_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;

  // Only first-time votes count; later strobes from a voted judge are dropped.
  logic [N_JUDGE-1:0] fresh_s;
  assign fresh_s = bus.vote_valid & ~voted_r;

  // State and registered outputs; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= 16'd0;
      voted_r <= '0;
      yes_r   <= '0;
      no_r    <= '0;
      pass_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      voted_r <= voted_s;
      yes_r   <= yes_s;
      no_r    <= no_s;
      pass_r  <= pass_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    voted_s = voted_r;
    yes_s   = yes_r;
    no_s    = no_r;
    pass_s  = pass_r;
    done_s  = 1'b0;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = COLLECT;
          timer_s = 16'd0;
          voted_s = '0;
          yes_s   = '0;
          no_s    = '0;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      COLLECT: begin
        voted_s = voted_r | fresh_s;
        yes_s   = yes_r + popcount(fresh_s & bus.vote_val);
        no_s    = no_r + popcount(fresh_s & ~bus.vote_val);
        timer_s = timer_r + 16'd1;
        busy_s  = 1'b1;
        // Votes landing on the closing edge are already folded into the counts.
        if ((&voted_s) || (timer_r == LAST_TICK)) begin
          state_s = RESULT;
          done_s  = 1'b1;
          if (PASS_MODE == 1) begin
            pass_s = (yes_s == ALL_CNT);
          end else begin
            pass_s = (yes_s > HALF_CNT);
          end
        end else begin
          state_s = COLLECT;
        end
      end
      RESULT: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.pass    = pass_r;
  assign bus.yes_cnt = yes_r;
  assign bus.no_cnt  = no_r;
  assign bus.voted   = voted_r;
endmodule

// File: doc/lzx_vote_panel.md
LZX_VOTE_PANEL -- requirements
Module: lzx_vote_panel

Interface
REQ-001 Parameter N_JUDGE, default 5, number of judge channels; legal range 1..16.
REQ-002 Parameter TIMEOUT_CYC, default 8, length of the vote window in clock cycles; legal range 2..65535.
REQ-003 Parameter PASS_MODE, default 0, decision rule: 0 = strict majority, 1 = unanimous.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to open a vote window.
REQ-007 vote_valid  input  N_JUDGE  per-judge vote strobe.
REQ-008 vote_val  input  N_JUDGE  per-judge vote value: 1 = yes, 0 = no; sampled only with the matching vote_valid bit.
REQ-009 busy  output  1  high while a window is open or a result is being issued.
REQ-010 done  output  1  single-cycle result strobe.
REQ-011 pass  output  1  decision of the last completed window.
REQ-012 yes_cnt  output  CW  number of yes votes, where CW = $clog2(N_JUDGE+1).
REQ-013 no_cnt  output  CW  number of no votes.
REQ-014 voted  output  N_JUDGE  per-judge mask of votes captured in the current or last window.

Function
REQ-015 The block SHALL implement the FSM states IDLE, COLLECT and RESULT; all outputs SHALL be registered.
REQ-016 IDLE -> COLLECT SHALL occur on the edge where start=1; on that edge voted, yes_cnt, no_cnt and the window timer SHALL clear to 0, and busy SHALL go to 1.
REQ-017 start SHALL be ignored in COLLECT and RESULT.
REQ-018 In COLLECT, judge i SHALL be captured on an edge where vote_valid[i]=1 and voted[i]=0: voted[i] sets to 1, and yes_cnt or no_cnt increments according to vote_val[i].
REQ-019 Votes are sticky, so a further vote_valid[i] from an already-voted judge SHALL be ignored.
REQ-020 Simultaneous votes from any number of judges on the same edge SHALL all be captured, with the counters incremented by the population counts.
REQ-021 The timer SHALL count COLLECT cycles from 0.
REQ-022 COLLECT -> RESULT SHALL occur when all N_JUDGE bits of the next voted value are 1, or when the timer equals TIMEOUT_CYC-1, whichever comes first.
REQ-023 Votes presented on the transition edge SHALL be counted.
REQ-024 A window SHALL therefore occupy at most TIMEOUT_CYC COLLECT cycles.
REQ-025 Judges that have not voted when the window closes SHALL be treated as abstaining and SHALL count toward neither yes_cnt nor no_cnt.
REQ-026 On entering RESULT, pass SHALL be computed from the final counts: PASS_MODE=0 gives pass = (yes_cnt > N_JUDGE/2, integer division); PASS_MODE=1 gives pass = (yes_cnt == N_JUDGE).
REQ-027 In either mode, abstentions effectively count against the motion.
REQ-028 The block SHALL spend exactly one cycle in RESULT, with done=1 and busy=1, then return to IDLE with done=0 and busy=0.
REQ-029 pass, yes_cnt, no_cnt and voted SHALL hold their RESULT values through IDLE until the next accepted start.
REQ-030 Latency from the closing vote edge to done=1 SHALL be 1 cycle.
REQ-031 Latency from the start edge to the earliest possible done SHALL be 2 cycles (N_JUDGE votes on the first COLLECT edge).
REQ-032 vote_valid in IDLE or RESULT SHALL be ignored.
REQ-033 Counters SHALL NOT overflow, because their sum is bounded by N_JUDGE by construction.

Reset
REQ-034 rst=1 SHALL take precedence over every other input on the same edge.
REQ-035 On reset the FSM SHALL go to IDLE with busy=0, done=0, pass=0, yes_cnt=0, no_cnt=0, voted=0 and timer=0.
REQ-036 Reset in COLLECT or RESULT SHALL abort the window with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (N_JUDGE=5, TIMEOUT_CYC=8 unless stated)
REQ-037 Majority pass: start, then one cycle later vote_valid=5'b11111 with vote_val=5'b00111 -> next cycle done=1, pass=1, yes_cnt=3, no_cnt=2, voted=5'b11111; the following cycle busy=0 and outputs held.
REQ-038 Timeout with abstentions: start; judges 0 and 1 vote yes on COLLECT cycle 2; nothing else -> done on the cycle after COLLECT cycle 7, pass=0, yes_cnt=2, no_cnt=0, voted=5'b00011.
REQ-039 Sticky and duplicate votes: judge 2 votes yes, then re-strobes with vote_val=0 -> yes_cnt stays 1, no_cnt stays 0; vote_valid and start pulsed while busy or in IDLE -> no effect.
REQ-040 Last-cycle vote: the fifth judge's vote lands exactly on COLLECT cycle 7 -> it is counted, voted=5'b11111, single done pulse.
REQ-041 Unanimous mode (PASS_MODE=1): 4 yes and 1 no -> pass=0; 5 yes -> pass=1.
REQ-042 Mid-window reset: rst asserted in COLLECT after 2 votes -> next cycle all outputs 0 and no done; a new start then runs a full window correctly.
